// File: rtl/pdh_pkg.sv
// Shared definitions for the pdh GPIO command/response path: word layout,
// response codes and the response transmitter state encoding.
package pdh_pkg;

   localparam int AXI_GPIO_OUT_WIDTH = 32;
   localparam int CMD_BITS           = 4;
   localparam int DATA_BITS          = 28;
   localparam int RSP_CODE_BITS      = 4;
   localparam int RSP_DATA_BITS      = 27;
   localparam int RSP_TOGGLE_BIT     = 27;

   typedef enum logic [3:0] {
      RSP_NONE   = 4'h0,
      RSP_ACK    = 4'h1,
      RSP_LED    = 4'h2,
      RSP_STATUS = 4'h3,
      RSP_ERR    = 4'hF
   } rsp_code_t;

   typedef enum logic [1:0] {
      RESYNC   = 2'd0,
      IDLE     = 2'd1,
      WAIT_ACK = 2'd2
   } tx_state_t;

endpackage

// File: rtl/pdh_sync_fifo.sv
// Small synchronous FIFO with level output; push is ignored when full and
// pop is ignored when empty, so a full FIFO never accepts a write even on a pop.
module pdh_sync_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pdh_resp_tx.sv
// Response transmitter toward the PS: buffers records and presents one at a
// time on the GPIO word with a toggle flag that the PS echoes back as its ack.
module pdh_resp_tx #(
   parameter int AXI_GPIO_OUT_WIDTH = pdh_pkg::AXI_GPIO_OUT_WIDTH,
   parameter int RSP_CODE_BITS      = pdh_pkg::RSP_CODE_BITS,
   parameter int RSP_DATA_BITS      = pdh_pkg::RSP_DATA_BITS,
   parameter int FIFO_DEPTH         = 4,
   parameter int TIMEOUT_CYCLES     = 125000000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            rsp_valid_i,
   output logic                            rsp_ready_o,
   input  logic [RSP_CODE_BITS-1:0]        rsp_code_i,
   input  logic [RSP_DATA_BITS-1:0]        rsp_data_i,
   input  logic                            ps_ack_i,
   input  logic                            clear_i,
   output logic [AXI_GPIO_OUT_WIDTH-1:0]   axi_to_ps_o,
   output logic                            busy_o,
   output logic                            timeout_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

   import pdh_pkg::*;

   localparam int REC_W = RSP_CODE_BITS + RSP_DATA_BITS;
   localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

   tx_state_t                         state_q, state_d;
   logic                              ack_m, ack_s;
   logic [1:0]                        settle_q;
   logic                              toggle_q;
   logic                              busy_q;
   logic                              timeout_q;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic [AXI_GPIO_OUT_WIDTH-1:0]     word_q;
   logic                              pop;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic [REC_W-1:0]                  fifo_rdata;

   pdh_sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_valid_i),
      .wdata ({rsp_code_i, rsp_data_i}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level_o)
   );

   assign rsp_ready_o = !fifo_full;
   assign axi_to_ps_o = word_q;
   assign busy_o      = busy_q;
   assign timeout_o   = timeout_q;

   // The settle pipe keeps RESYNC from comparing against the reset value of
   // the synchroniser before the real ack level has propagated through it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_m    <= 1'b0;
         ack_s    <= 1'b0;
         settle_q <= 2'b00;
      end else begin
         ack_m    <= ps_ack_i;
         ack_s    <= ack_m;
         settle_q <= {settle_q[0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         RESYNC: begin
            if (settle_q[1] && (ack_s == toggle_q)) state_d = IDLE;
         end
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_s == toggle_q) begin
               if (!fifo_empty) pop = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = RESYNC;
      endcase
      if (pop || (state_d != WAIT_ACK)) cnt_d = '0;
      else if (cnt_q != TMO)            cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RESYNC;
         toggle_q  <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         word_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == WAIT_ACK);
         cnt_q   <= cnt_d;
         if (pop) begin
            toggle_q <= ~toggle_q;
            word_q   <= {fifo_rdata[REC_W-1 -: RSP_CODE_BITS], ~toggle_q,
                         fifo_rdata[RSP_DATA_BITS-1:0]};
         end
         // Set has priority; a clear is refused while the counter is saturated.
         if (cnt_d == TMO)                    timeout_q <= 1'b1;
         else if (clear_i && (cnt_q != TMO))  timeout_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pdh_resp_tx.sv
// Scoreboard bench for pdh_resp_tx: stimulus queues expected GPIO words, a
// monitor compares each newly presented record (toggle change) in order.
module tb_pdh_resp_tx;

   logic        clk;
   logic        rst_n;
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   logic [3:0]  rsp_code_i;
   logic [26:0] rsp_data_i;
   logic        ps_ack_i;
   logic        clear_i;
   logic [31:0] axi_to_ps_o;
   logic        busy_o;
   logic        timeout_o;
   logic [2:0]  fifo_level_o;

   int          total = 0;
   int          bad   = 0;
   int          n_pushed = 0;
   logic [31:0] sb[$];

   pdh_resp_tx #(
      .AXI_GPIO_OUT_WIDTH (32),
      .RSP_CODE_BITS      (4),
      .RSP_DATA_BITS      (27),
      .FIFO_DEPTH         (4),
      .TIMEOUT_CYCLES     (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rsp_valid_i  (rsp_valid_i),
      .rsp_ready_o  (rsp_ready_o),
      .rsp_code_i   (rsp_code_i),
      .rsp_data_i   (rsp_data_i),
      .ps_ack_i     (ps_ack_i),
      .clear_i      (clear_i),
      .axi_to_ps_o  (axi_to_ps_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o),
      .fifo_level_o (fifo_level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic boundFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: wait budget expired", name);
   endtask

   // Push one record; the nth record since reset is presented with toggle = n odd.
   task automatic applyStimulus(input logic [3:0] code, input logic [26:0] data);
      logic tog;
      bit   done;
      done        = 0;
      rsp_valid_i = 1'b1;
      rsp_code_i  = code;
      rsp_data_i  = data;
      for (int i = 0; i < 20 && !done; i++) begin
         if (rsp_ready_o) begin
            @(posedge clk);
            n_pushed++;
            tog = n_pushed[0];
            sb.push_back({code, tog, data});
            done = 1;
         end
         @(negedge clk);
      end
      rsp_valid_i = 1'b0;
      if (!done) boundFail("push_ready");
   endtask

   task automatic waitBusy(input logic want, input int budget, input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (busy_o == want) ok = 1;
      end
      if (!ok) boundFail(name);
   endtask

   task automatic waitToggleChange(input int budget, input string name);
      logic prev;
      bit   ok;
      prev = axi_to_ps_o[27];
      ok   = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (axi_to_ps_o[27] != prev) ok = 1;
      end
      if (!ok) boundFail(name);
   endtask

   task automatic doReset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      sb.delete();
      n_pushed = 0;
      rst_n = 1'b1;
   endtask

   // Monitor: a change of the toggle bit outside reset marks a new record.
   initial begin : monitor
      logic        prev_tog;
      logic [31:0] exp;
      prev_tog = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_tog = 1'b0;
         end else if (axi_to_ps_o[27] != prev_tog) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_record: got %h want none", axi_to_ps_o);
            end else begin
               exp = sb.pop_front();
               checkOutput("record", axi_to_ps_o, exp);
            end
            prev_tog = axi_to_ps_o[27];
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_code_i  = 4'h0;
      rsp_data_i  = 27'h0;
      ps_ack_i    = 1'b0;
      clear_i     = 1'b0;
      @(negedge clk);
      doReset(3);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_word", axi_to_ps_o, 32'h0);
      checkOutput("reset_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("reset_timeout", {31'h0, timeout_o}, 32'h0);
      checkOutput("reset_level", {29'h0, fifo_level_o}, 32'h0);
      checkOutput("reset_ready", {31'h0, rsp_ready_o}, 32'h1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] first record");
      applyStimulus(4'h1, 27'h0000ABC);
      @(negedge clk);
      checkOutput("first_word", axi_to_ps_o, 32'h18000ABC);
      checkOutput("first_busy", {31'h0, busy_o}, 32'h1);

      ps_ack_i = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("ack_busy_edge2", {31'h0, busy_o}, 32'h1);
      @(negedge clk);
      checkOutput("ack_busy_edge3", {31'h0, busy_o}, 32'h0);
      checkOutput("ack_word_hold", axi_to_ps_o, 32'h18000ABC);

      $display("[TB] fill fifo");
      applyStimulus(4'h2, 27'h0000001);
      applyStimulus(4'h3, 27'h0000022);
      applyStimulus(4'hF, 27'h0000333);
      applyStimulus(4'h1, 27'h7FFFFFF);
      applyStimulus(4'h0, 27'h5555555);
      checkOutput("full_level", {29'h0, fifo_level_o}, 32'h4);
      checkOutput("full_ready", {31'h0, rsp_ready_o}, 32'h0);
      checkOutput("full_busy", {31'h0, busy_o}, 32'h1);
      checkOutput("full_word", axi_to_ps_o, 32'h20000001);

      for (int k = 0; k < 4; k++) begin
         ps_ack_i = axi_to_ps_o[27];
         waitToggleChange(10, "drain_next");
         if (k == 0) checkOutput("drain_ready", {31'h0, rsp_ready_o}, 32'h1);
      end
      ps_ack_i = axi_to_ps_o[27];
      waitBusy(1'b0, 10, "drain_idle");
      checkOutput("drain_level", {29'h0, fifo_level_o}, 32'h0);
      checkOutput("drain_sb_empty", sb.size(), 32'h0);

      $display("[TB] stale ack through reset");
      ps_ack_i = 1'b1;
      doReset(3);
      repeat (6) @(negedge clk);
      applyStimulus(4'h3, 27'h1234567);
      repeat (6) @(negedge clk);
      checkOutput("resync_word", axi_to_ps_o, 32'h0);
      checkOutput("resync_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("resync_level", {29'h0, fifo_level_o}, 32'h1);
      ps_ack_i = 1'b0;
      waitBusy(1'b1, 10, "resync_present");
      checkOutput("resync_present_word", axi_to_ps_o, 32'h39234567);

      $display("[TB] timeout");
      repeat (99) @(negedge clk);
      checkOutput("timeout_99", {31'h0, timeout_o}, 32'h0);
      @(negedge clk);
      checkOutput("timeout_100", {31'h0, timeout_o}, 32'h1);
      checkOutput("timeout_word_held", axi_to_ps_o, 32'h39234567);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      checkOutput("timeout_clear_blocked", {31'h0, timeout_o}, 32'h1);
      ps_ack_i = 1'b1;
      waitBusy(1'b0, 10, "timeout_ack");
      checkOutput("timeout_ack_word", axi_to_ps_o, 32'h39234567);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      checkOutput("timeout_cleared", {31'h0, timeout_o}, 32'h0);
      checkOutput("timeout_sb_empty", sb.size(), 32'h0);

      $display("[TB] reset mid operation");
      applyStimulus(4'h2, 27'h0000010);
      applyStimulus(4'h2, 27'h0000020);
      applyStimulus(4'h2, 27'h0000030);
      applyStimulus(4'h2, 27'h0000040);
      checkOutput("mid_level", {29'h0, fifo_level_o}, 32'h3);
      checkOutput("mid_busy", {31'h0, busy_o}, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_word", axi_to_ps_o, 32'h0);
      checkOutput("mid_rst_level", {29'h0, fifo_level_o}, 32'h0);
      checkOutput("mid_rst_busy", {31'h0, busy_o}, 32'h0);
      checkOutput("mid_rst_ready", {31'h0, rsp_ready_o}, 32'h1);
      sb.delete();
      n_pushed = 0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdh_resp_tx.md
Name: pdh_resp_tx

Overview:
- Response transmitter toward the PS over the 32-bit AXI GPIO output word; it is the return path for the command words the PS writes into pdh_core.
- Accepts response records (4-bit code plus 27-bit payload) from core logic through a valid/ready port and buffers them in a small FIFO.
- Presents one record at a time on axi_to_ps_o with a toggle flag. Each record is held until the PS echoes that toggle on its ack bit, so no record is lost while the PS polls at software rate.

Parameters:
- AXI_GPIO_OUT_WIDTH, 32, width of the word presented to the PS.
- RSP_CODE_BITS, 4, response code field width.
- RSP_DATA_BITS, 27, payload width. RSP_CODE_BITS + 1 + RSP_DATA_BITS must equal AXI_GPIO_OUT_WIDTH.
- FIFO_DEPTH, 4, record buffer depth; power of 2, at least 2.
- TIMEOUT_CYCLES, 125000000, cycles without ack before timeout_o is set (1 s at 125 MHz).

Ports:
- clk  in  1  FCLK_CLK0, 125 MHz.
- rst_n  in  1  synchronous, active-low reset.
- rsp_valid_i  in  1  producer has a record.
- rsp_ready_o  out  1  FIFO can accept a record.
- rsp_code_i  in  RSP_CODE_BITS  response code.
- rsp_data_i  in  RSP_DATA_BITS  response payload.
- ps_ack_i  in  1  PS ack toggle, one GPIO input bit, asynchronous to clk.
- clear_i  in  1  clears the sticky timeout_o.
- axi_to_ps_o  out  AXI_GPIO_OUT_WIDTH  word to PS: [31:28] code, [27] toggle, [26:0] payload.
- busy_o  out  1  a presented record is not yet acked.
- timeout_o  out  1  sticky ack timeout flag.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  records currently buffered.

Behaviour:
- Reset is synchronous and active-low on clk: reset is rst_n, clock is clk.
- Reset values: axi_to_ps_o=0, toggle=0, busy_o=0, timeout_o=0, fifo_level_o=0, FIFO emptied, ack synchroniser=0, FSM in RESYNC.
- Reset is effective mid-operation: the pending record and all buffered records are discarded.
- ps_ack_i passes through a 2-FF synchroniser to give ack_s. A change on ps_ack_i reaches ack_s after the second rising edge.
- Push: a record is written on an edge where rsp_valid_i && rsp_ready_o.
- rsp_ready_o = !full, combinational from the FIFO level. There is no write-when-full bypass, even if a pop occurs in the same cycle.
- A simultaneous push and pop leaves the level unchanged.
- States:
  - RESYNC: entered from reset. Waits until ack_s == toggle, which guards against a stale PS ack=1 left over from before reset. Then goes to IDLE. The FIFO still accepts pushes in this state.
  - IDLE: toggle == ack_s and nothing is pending. If the FIFO is non-empty on an edge: pop, register code and payload into axi_to_ps_o, invert toggle, set busy_o=1, go to WAIT_ACK, clear the timeout counter.
  - WAIT_ACK: axi_to_ps_o is held stable. On an edge where ack_s == toggle:
    - FIFO non-empty: pop and present the next record with toggle inverted again, stay in WAIT_ACK, reset the counter.
    - FIFO empty: busy_o=0, go to IDLE. axi_to_ps_o keeps the last record.
- Latency: a push on edge E0 into an empty FIFO in IDLE appears on axi_to_ps_o after edge E0+1.
- Ack-to-next-record latency: ps_ack_i change, then 2 edges for synchronisation, then the next record appears on the 3rd edge.
- Timeout:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments every cycle in WAIT_ACK and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets timeout_o. The record is NOT dropped; the FSM keeps waiting.
  - timeout_o clears only on clear_i=1 while the counter is not at TIMEOUT_CYCLES. If set and clear occur in the same cycle, set wins.
- ack_s toggling while in IDLE or RESYNC is ignored except for the RESYNC compare. No state change occurs in IDLE.
- Payload bits wider than RSP_DATA_BITS are not permitted; the producer truncates before pushing.

Decomposition:
- Shared package pdh_pkg:
  - GPIO word widths and field offsets: CMD_BITS=4, DATA_BITS=28, RSP_CODE_BITS, RSP_DATA_BITS, RSP_TOGGLE_BIT=27.
  - rsp_code_t enum: RSP_NONE=4'h0, RSP_ACK=4'h1, RSP_LED=4'h2, RSP_STATUS=4'h3, RSP_ERR=4'hF.
  - FSM state typedef.
- One sub-module, pdh_sync_fifo: parameterised width and depth, with push/pop/full/empty/level outputs.
- The synchroniser and FSM stay in pdh_resp_tx.

Test Plan:
- Reset with ps_ack_i=0, push code 4'h1 / payload 27'h0000ABC -> axi_to_ps_o=32'h18000ABC one edge after the push; busy_o=1.
- Then drive ps_ack_i=1 -> busy_o=0 on the 3rd edge; axi_to_ps_o unchanged.
- Push 5 records back-to-back with no ack (depth 4) -> 1 record presented, 4 buffered, rsp_ready_o=0, fifo_level_o=4.
- Continue by toggling ack 4 times -> records emerge in order with the toggle alternating 0→1→0→1→0, and rsp_ready_o returns to 1.
- Hold ps_ack_i=1 through reset, then push -> FSM stays in RESYNC and nothing is presented. Drive ps_ack_i=0 -> record presented with toggle=1.
- TIMEOUT_CYCLES=100, present a record, withhold ack -> timeout_o=1 at cycle 100 and the record is still held. Then pulse clear_i -> timeout_o stays 1 while the counter is saturated.
- Continue by acking, then pulsing clear_i -> timeout_o=0.
- Assert rst_n=0 while 3 records are buffered and 1 is pending -> next cycle axi_to_ps_o=0, fifo_level_o=0, busy_o=0, rsp_ready_o=1.
